// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, imem request/response handshake,
// IF/ID write control, and delivery/wait performance counters.
module fetch_ctrl #(
   parameter int P_WIDTH = 32,
   parameter int P_CNT_W = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [P_WIDTH-1:0] i_pc,
   input  logic               i_stall,
   input  logic               i_flush,
   output logic               o_pc_en,
   output logic               o_pc_sel,
   output logic               o_imem_req,
   output logic [P_WIDTH-1:0] o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic               i_imem_rvalid,
   output logic               o_imem_rready,
   output logic               o_ifid_en,
   output logic               o_ifid_valid,
   output logic [P_CNT_W-1:0] o_fetch_cnt,
   output logic [P_CNT_W-1:0] o_wait_cnt
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_DISCARD
   } state_e;

   state_e state_q, state_d;
   logic [P_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [P_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic deliver;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_BOOT;
         fetch_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      o_pc_en       = 1'b0;
      o_pc_sel      = 1'b0;
      o_imem_req    = 1'b0;
      o_imem_rready = 1'b0;
      o_ifid_en     = 1'b0;
      o_ifid_valid  = 1'b0;
      deliver       = 1'b0;
      if (!i_rst) begin
         unique case (state_q)
            S_BOOT: begin
               state_d = S_REQ;
               if (i_flush) begin
                  o_pc_en  = 1'b1;
                  o_pc_sel = 1'b1;
               end
            end
            S_REQ: begin
               if (i_flush) begin
                  o_pc_en    = 1'b1;
                  o_pc_sel   = 1'b1;
                  o_ifid_en  = 1'b1;
                  // an already-granted request stays visible for its handshake
                  o_imem_req = i_imem_gnt;
                  if (i_imem_gnt) state_d = S_DISCARD;
               end else begin
                  o_imem_req = 1'b1;
                  if (i_imem_gnt) state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_flush) begin
                  o_pc_en   = 1'b1;
                  o_pc_sel  = 1'b1;
                  o_ifid_en = 1'b1;
                  if (i_imem_rvalid) begin
                     o_imem_rready = 1'b1;
                     state_d       = S_REQ;
                  end else begin
                     state_d = S_DISCARD;
                  end
               end else if (i_imem_rvalid && !i_stall) begin
                  deliver       = 1'b1;
                  o_imem_rready = 1'b1;
                  o_ifid_en     = 1'b1;
                  o_ifid_valid  = 1'b1;
                  o_pc_en       = 1'b1;
                  state_d       = S_REQ;
               end
            end
            S_DISCARD: begin
               o_imem_rready = 1'b1;
               if (i_flush) begin
                  o_pc_en  = 1'b1;
                  o_pc_sel = 1'b1;
               end
               // the dropped response always frees the slot, even on a new flush
               if (i_imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_BOOT;
         endcase
      end
   end

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      if (deliver) fetch_cnt_d = fetch_cnt_q + 1'b1;
      if (state_q == S_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   assign o_imem_addr = o_imem_req ? i_pc : '0;
   assign o_fetch_cnt = fetch_cnt_q;
   assign o_wait_cnt  = wait_cnt_q;

endmodule
